// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_access_stage_pkg : access-type codes, bus sizes, MEM states |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package mem_access_stage_pkg;

   localparam logic [2:0] c_lb  = 3'd0;
   localparam logic [2:0] c_lbu = 3'd1;
   localparam logic [2:0] c_lh  = 3'd2;
   localparam logic [2:0] c_lhu = 3'd3;
   localparam logic [2:0] c_lw  = 3'd4;
   localparam logic [2:0] c_sb  = 3'd5;
   localparam logic [2:0] c_sh  = 3'd6;
   localparam logic [2:0] c_sw  = 3'd7;

   localparam logic [1:0] c_size_byte = 2'd0;
   localparam logic [1:0] c_size_half = 2'd1;
   localparam logic [1:0] c_size_word = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [1:0] access_size(input logic [2:0] access_type);
      case (access_type)
         c_lb, c_lbu, c_sb: access_size = c_size_byte;
         c_lh, c_lhu, c_sh: access_size = c_size_half;
         c_lw, c_sw:        access_size = c_size_word;
         default:           access_size = c_size_word;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_access_stage_if : split-handshake data SRAM port            |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [3:0]        data_wstrb;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_access_stage_load_align : byte/half select and extension    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module mem_access_stage_load_align
   import mem_access_stage_pkg::*;
(
   input  wire logic [31:0] i_rdata,
   input  wire logic [2:0]  i_access_type,
   input  wire logic [1:0]  i_offset,
   output logic [31:0]      o_value
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[{i_offset, 3'b000} +: 8];
      w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_access_type)
         c_lb:    o_value = {{24{w_byte[7]}}, w_byte};
         c_lbu:   o_value = {24'd0, w_byte};
         c_lh:    o_value = {{16{w_half[15]}}, w_half};
         c_lhu:   o_value = {16'd0, w_half};
         default: o_value = i_rdata;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mem_access_stage : MEM pipeline stage, data SRAM access + MEM/WB|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic [31:0]       mem_pc,
   input  wire logic              mem_regfile_wren,
   input  wire logic [4:0]        mem_regfile_wt_addr,
   input  wire logic              mem_regfile_mem2reg,
   input  wire logic [DATA_W-1:0] mem_regfile_wt_val,
   input  wire logic [DATA_W-1:0] mem_regfile_rt_read_val,
   input  wire logic [ADDR_W-1:0] mem_dmm_addr,
   input  wire logic              mem_dmm_read,
   input  wire logic              mem_dmm_write,
   input  wire logic [3:0]        mem_dmm_byte_enable,
   input  wire logic [2:0]        mem_lw_sw_type,
   input  wire logic              mem_exc,
   input  wire logic              exception_flush,
   input  wire logic              pipe_advance,
   output logic                   ready,
   mem_access_stage_if.master     dbus,
   output logic [31:0]            wb_pc,
   output logic                   wb_regfile_wren,
   output logic [4:0]             wb_regfile_wt_addr,
   output logic [DATA_W-1:0]      wb_regfile_wt_val,
   output logic [DATA_W-1:0]      fwd_val
);
   state_t            r_state;
   logic              r_kill;
   logic [DATA_W-1:0] r_load_buf;
   logic [DATA_W-1:0] w_aligned;
   logic [DATA_W-1:0] w_wb_val;
   logic              w_mem_op;
   logic              w_drop;

   assign w_mem_op = (mem_dmm_read | mem_dmm_write) & ~mem_exc & ~exception_flush;
   assign w_drop   = exception_flush | mem_exc;

   assign dbus.data_req   = (r_state == ST_IDLE) & w_mem_op & ~reset;
   assign dbus.data_wr    = mem_dmm_write;
   assign dbus.data_size  = access_size(mem_lw_sw_type);
   assign dbus.data_addr  = mem_dmm_addr;
   assign dbus.data_wstrb = mem_dmm_write ? mem_dmm_byte_enable : 4'b0000;

   always_comb begin
      case (mem_lw_sw_type)
         c_sb:    dbus.data_wdata = {4{mem_regfile_rt_read_val[7:0]}};
         c_sh:    dbus.data_wdata = {2{mem_regfile_rt_read_val[15:0]}};
         default: dbus.data_wdata = mem_regfile_rt_read_val;
      endcase
   end

   assign ready = ((r_state == ST_IDLE) & ~w_mem_op)
                | ((r_state == ST_WAIT) & dbus.data_data_ok)
                |  (r_state == ST_DONE);

   mem_access_stage_load_align u_load_align (
      .i_rdata       (dbus.data_rdata),
      .i_access_type (mem_lw_sw_type),
      .i_offset      (mem_dmm_addr[1:0]),
      .o_value       (w_aligned)
   );

   // Once parked in DONE the bus data is gone; only load_buf is valid.
   assign w_wb_val = !mem_regfile_mem2reg  ? mem_regfile_wt_val :
                     (r_state == ST_DONE) ? r_load_buf : w_aligned;
   assign fwd_val  = w_wb_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state            <= ST_IDLE;
         r_kill             <= 1'b0;
         r_load_buf         <= '0;
         wb_pc              <= '0;
         wb_regfile_wren    <= 1'b0;
         wb_regfile_wt_addr <= '0;
         wb_regfile_wt_val  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mem_op && dbus.data_addr_ok)
                  r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (dbus.data_data_ok && pipe_advance) begin
                  r_state <= ST_IDLE;
                  r_kill  <= 1'b0;
               end else if (dbus.data_data_ok) begin
                  r_state    <= ST_DONE;
                  r_load_buf <= w_aligned;
                  r_kill     <= r_kill | exception_flush;
               end else if (exception_flush) begin
                  r_kill <= 1'b1;
               end
            end
            ST_DONE: begin
               if (pipe_advance) begin
                  r_state <= ST_IDLE;
                  r_kill  <= 1'b0;
               end else if (exception_flush) begin
                  r_kill <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (pipe_advance) begin
            wb_pc              <= mem_pc;
            wb_regfile_wren    <= mem_regfile_wren & ~w_drop & ~r_kill;
            wb_regfile_wt_addr <= w_drop ? 5'd0 : mem_regfile_wt_addr;
            wb_regfile_wt_val  <= w_wb_val;
         end
      end
   end
endmodule
`default_nettype wire
